// File: rtl/tx_bit_timer_param_if.sv
// Timer-side bundle between the TX controller FSM and the bit/byte timer.
// Optional cfg_clks_per_bit is present only with TX_TIMER_DYN_RATE_EN.
interface tx_bit_timer_param_if #(
    parameter int BW = 4,
    parameter int CW = 5
);
    logic          timer_enable;
    logic          timer_clear;
    logic          tx_transfer_active;
    logic          strobe;
    logic          strobe_middle;
    logic          byte_transmitted;
    logic          long_byte;
    logic [BW-1:0] bit_index;
`ifdef TX_TIMER_DYN_RATE_EN
    logic [CW-1:0] cfg_clks_per_bit;
`endif

    modport master (
        output timer_enable, timer_clear, tx_transfer_active,
`ifdef TX_TIMER_DYN_RATE_EN
        output cfg_clks_per_bit,
`endif
        input  strobe, strobe_middle, byte_transmitted, long_byte, bit_index
    );

    modport slave (
        input  timer_enable, timer_clear, tx_transfer_active,
`ifdef TX_TIMER_DYN_RATE_EN
        input  cfg_clks_per_bit,
`endif
        output strobe, strobe_middle, byte_transmitted, long_byte, bit_index
    );
endinterface

// File: rtl/tx_bit_timer_param.sv
// Bit/byte timing generator: bit strobes, mid-bit strobes, byte ends, periodic long bytes.
// Pulses decode registered counters combinationally; TX_TIMER_DYN_RATE_EN adds a runtime bit rate.
module tx_bit_timer_param #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int MID_POINT     = 4,
    parameter int BITS_PER_BYTE = 8,
    parameter int LONG_PERIOD   = 3,
    parameter int LONG_EXTRA    = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    tx_bit_timer_param_if.slave  tif
);
    localparam int BW = $clog2(BITS_PER_BYTE + LONG_EXTRA + 1);
    localparam int CW = $clog2(CLKS_PER_BIT + 1) + 1;
    localparam int PW = (LONG_PERIOD > 1) ? $clog2(LONG_PERIOD) : 1;
    localparam logic [PW-1:0] PH_LAST = (LONG_PERIOD > 0) ? PW'(LONG_PERIOD - 1) : '0;
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic {SHORT, LONG} byte_state_e;
    // With LONG_PERIOD=1 every byte, including the first one, is stretched.
    localparam byte_state_e ST_INIT = (LONG_PERIOD == 1) ? LONG : SHORT;

    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    byte_state_e   state_q, state_d;
    logic [CW-1:0] rate, mid;
    logic [BW-1:0] bit_last;
    logic          adv, strobe, byte_end;

`ifdef TX_TIMER_DYN_RATE_EN
    logic [CW-1:0] rate_q, rate_d;

    always_comb begin
        rate_d = rate_q;
        if (tif.timer_clear)
            rate_d = (tif.cfg_clks_per_bit < CW'(2)) ? CW'(2) : tif.cfg_clks_per_bit;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) rate_q <= CW'(CLKS_PER_BIT);
        else        rate_q <= rate_d;
    end

    assign rate = rate_q;
    assign mid  = rate_q >> 1;
`else
    assign rate = CW'(CLKS_PER_BIT);
    assign mid  = CW'(MID_POINT);
`endif

    assign adv      = tif.timer_enable & ~tif.timer_clear;
    assign strobe   = adv & (clk_cnt_q == rate - ONE_C);
    assign bit_last = BW'(BITS_PER_BYTE - 1) + ((state_q == LONG) ? BW'(LONG_EXTRA) : BW'(0));
    assign byte_end = strobe & (bit_cnt_q == bit_last);

    always_comb begin
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        state_d   = state_q;
        if (tif.timer_clear) begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            phase_d   = '0;
            state_d   = ST_INIT;
        end else if (tif.timer_enable) begin
            clk_cnt_d = strobe ? '0 : clk_cnt_q + ONE_C;
            if (strobe)
                bit_cnt_d = byte_end ? '0 : bit_cnt_q + BW'(1);
            if (byte_end) begin
                phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
                state_d = ((LONG_PERIOD != 0) && (phase_d == PH_LAST)) ? LONG : SHORT;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            phase_q   <= '0;
            state_q   <= ST_INIT;
        end else begin
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            state_q   <= state_d;
        end
    end

    assign tif.strobe           = strobe;
    assign tif.strobe_middle    = adv & tif.tx_transfer_active & (clk_cnt_q == mid - ONE_C);
    assign tif.byte_transmitted = byte_end;
    assign tif.long_byte        = (state_q == LONG);
    assign tif.bit_index        = bit_cnt_q;
endmodule
